mem_port_arbiter: RTL and testbench

Shares the single-ported unified memory between the fetch stage (instruction port) and the mem stage (data port). Arbitrates and registers one request, issues it downstream, tracks the single outstanding transaction, and routes the response back to its owner. Discards fetch responses invalidated by a commit-time branch redirect. Sits between `fetch`/`mem` and the memory model in the datapath top.

---
 rtl/tartaruga_pkg.sv | 27 ++
 rtl/mem_arb_picker.sv | 56 +++++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga core memory path: arbiter state, owner tag and the
// latched downstream request payload.
package tartaruga_pkg;

  localparam int unsigned TARTARUGA_ADDR_W = 32;
  localparam int unsigned TARTARUGA_DATA_W = 32;
  localparam int unsigned TARTARUGA_BE_W   = TARTARUGA_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic [TARTARUGA_ADDR_W-1:0] addr;
    logic                        we;
    logic [TARTARUGA_DATA_W-1:0] wdata;
    logic [TARTARUGA_BE_W-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Winner selection for the shared memory port: data beats fetch, except that with
// TARTARUGA_ARB_FAIRNESS_EN defined a starvation counter hands fetch a turn.
module mem_arb_picker #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pick_en_i,
  input  logic if_req_i,
  input  logic if_pending_i,
  input  logic dm_req_i,
  output logic if_win_c,
  output logic dm_win_c
);

`ifdef TARTARUGA_ARB_FAIRNESS_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             starve_full;

  assign starve_full = (starve_q == CNT_W'(STARVE_LIMIT));

  // Counts data grants that left a fetch request waiting; saturates at the limit.
  always_comb begin
    dm_win_c = pick_en_i && dm_req_i && !(starve_full && if_req_i);
    if_win_c = pick_en_i && if_req_i && !dm_win_c;
    starve_d = starve_q;
    if (if_win_c) begin
      starve_d = '0;
    end else if (dm_win_c) begin
      if (!if_pending_i) begin
        starve_d = '0;
      end else if (!starve_full) begin
        starve_d = starve_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_ok;

  assign dm_win_c  = pick_en_i && dm_req_i;
  assign if_win_c  = pick_en_i && if_req_i && !dm_req_i;
  assign unused_ok = ^{clk_i, rst_i, if_pending_i, (STARVE_LIMIT == 0)};
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported memory between fetch and data; one outstanding transaction,
// flush-killed fetch responses are swallowed. Optional fairness: TARTARUGA_ARB_FAIRNESS_EN.
module mem_port_arbiter
  import tartaruga_pkg::*;
#(
  parameter int unsigned ADDR_W       = TARTARUGA_ADDR_W,
  parameter int unsigned DATA_W       = TARTARUGA_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                dm_req_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic                dm_we_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  output logic                dm_gnt_o,
  output logic                dm_rvalid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                mem_req_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_we_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_ready_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  mem_req_t   req_q, req_d;
  logic       drop_q, drop_d;

  logic pick_en;
  logic if_win_c;
  logic dm_win_c;
  logic fetch_killed;

  assign pick_en      = (state_q == ARB_IDLE) && !rst_i;
  assign fetch_killed = flush_i && (owner_q == OWNER_IF);

  mem_arb_picker #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_picker (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pick_en_i    (pick_en),
    .if_req_i     (if_req_i && !flush_i),
    .if_pending_i (if_req_i),
    .dm_req_i     (dm_req_i),
    .if_win_c     (if_win_c),
    .dm_win_c     (dm_win_c)
  );

  // Next state, request latch and the combinational grant/response strobes.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    req_d       = req_q;
    drop_d      = drop_q;
    if_gnt_o    = 1'b0;
    dm_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    dm_rvalid_o = 1'b0;
    mem_req_o   = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        drop_d = 1'b0;
        if (dm_win_c) begin
          dm_gnt_o = 1'b1;
          owner_d  = OWNER_DM;
          req_d    = '{addr:  TARTARUGA_ADDR_W'(dm_addr_i),
                       we:    dm_we_i,
                       wdata: TARTARUGA_DATA_W'(dm_wdata_i),
                       be:    TARTARUGA_BE_W'(dm_be_i)};
          state_d  = ARB_ISSUE;
        end else if (if_win_c) begin
          if_gnt_o = 1'b1;
          owner_d  = OWNER_IF;
          req_d    = '{addr:  TARTARUGA_ADDR_W'(if_addr_i),
                       we:    1'b0,
                       wdata: '0,
                       be:    '0};
          state_d  = ARB_ISSUE;
        end
      end

      ARB_ISSUE: begin
        mem_req_o = 1'b1;
        if (fetch_killed) begin
          drop_d = 1'b1;
        end
        if (mem_ready_i) begin
          state_d = ARB_WAIT;
        end
      end

      ARB_WAIT: begin
        if (fetch_killed) begin
          drop_d = 1'b1;
        end
        if (mem_rvalid_i) begin
          if (owner_q == OWNER_IF) begin
            if_rvalid_o = !(drop_q || flush_i);
          end else begin
            dm_rvalid_o = 1'b1;
          end
          drop_d  = 1'b0;
          state_d = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    // Nothing escapes while reset is held, even mid-transaction.
    if (rst_i) begin
      if_gnt_o    = 1'b0;
      dm_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      dm_rvalid_o = 1'b0;
      mem_req_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_IF;
      req_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      drop_q  <= drop_d;
    end
  end

  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
  assign mem_addr_o  = rst_i ? '0 : ADDR_W'(req_q.addr);
  assign mem_we_o    = !rst_i && req_q.we;
  assign mem_wdata_o = rst_i ? '0 : DATA_W'(req_q.wdata);
  assign mem_be_o    = rst_i ? '0 : BE_W'(req_q.be);
  assign busy_o      = !rst_i && (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model checked every cycle plus directed
// literal expectations. Build with TARTARUGA_ARB_FAIRNESS_EN to exercise the fairness rule.
module tb_mem_port_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 4;
  localparam int unsigned LIMIT = 4;
`ifdef TARTARUGA_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1, flush_i = 1'b0;
  logic          if_req_i = 1'b0, dm_req_i = 1'b0, dm_we_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0, dm_addr_i = '0;
  logic [DW-1:0] dm_wdata_i = '0, mem_rdata_i = '0;
  logic [BW-1:0] dm_be_i = '0;
  logic          mem_ready_i = 1'b1, mem_rvalid_i = 1'b0;
  logic          if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_req_o, mem_we_o, busy_o;
  logic [DW-1:0] if_rdata_o, dm_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_be_o;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_addr_i(dm_addr_i), .dm_we_i(dm_we_i),
    .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%s required=%s", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] resp_of(input logic [AW-1:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // ---------------- requesters and memory responder ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } dm_op_t;

  dm_op_t        dm_q[$];
  logic [AW-1:0] if_q[$];
  dm_op_t        op;
  bit            if_gseen = 0, dm_gseen = 0, acc_seen = 0, rv_pending = 0;
  logic [AW-1:0] acc_addr = '0, rv_addr = '0;
  int            stall_left = 0, rv_delay = 0, rv_wait = 0;
  string         glog = "";
  logic [DW-1:0] if_resp[$], dm_resp[$];

  always @(negedge clk) begin
    if (if_gnt_o) begin if_gseen = 1; glog = {glog, "I"}; end
    if (dm_gnt_o) begin dm_gseen = 1; glog = {glog, "D"}; end
    if (if_rvalid_o) if_resp.push_back(if_rdata_o);
    if (dm_rvalid_o) dm_resp.push_back(dm_rdata_o);
    if (mem_req_o && !mem_ready_i && stall_left > 0) stall_left--;
    if (mem_req_o && mem_ready_i) begin acc_seen = 1; acc_addr = mem_addr_o; end
  end

  always @(posedge clk) begin
    #1;
    if (if_gseen) begin if_req_i = 1'b0; if_gseen = 0; end
    if (dm_gseen) begin dm_req_i = 1'b0; dm_gseen = 0; end
    if (!if_req_i && if_q.size() > 0) begin
      if_req_i = 1'b1; if_addr_i = if_q.pop_front();
    end
    if (!dm_req_i && dm_q.size() > 0) begin
      op = dm_q.pop_front();
      dm_req_i = 1'b1; dm_addr_i = op.addr; dm_we_i = op.we;
      dm_wdata_i = op.wdata; dm_be_i = op.be;
    end
    mem_rvalid_i = 1'b0;
    if (acc_seen) begin
      rv_pending = 1; rv_wait = rv_delay; rv_addr = acc_addr; acc_seen = 0;
    end
    if (rv_pending) begin
      if (rv_wait == 0) begin
        mem_rvalid_i = 1'b1; mem_rdata_i = resp_of(rv_addr); rv_pending = 0;
      end else begin
        rv_wait--;
      end
    end
    mem_ready_i = (stall_left == 0);
  end

  // ---------------- transaction-level model, compared every cycle ----------------
  bit            m_busy = 0, m_issued = 0, m_if = 0, m_drop = 0, m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [BW-1:0] m_be = '0;
  int            m_starve = 0;
  bit            e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv, e_mem_req, e_busy, fetch_ok;

  always @(negedge clk) begin
    e_if_gnt = 0; e_dm_gnt = 0; e_if_rv = 0; e_dm_rv = 0; e_mem_req = 0; e_busy = 0;
    if (!rst_i) begin
      if (!m_busy) begin
        fetch_ok = if_req_i && !flush_i;
        if (dm_req_i && !(FAIR && m_starve == LIMIT && fetch_ok)) e_dm_gnt = 1;
        else if (fetch_ok) e_if_gnt = 1;
      end else begin
        e_busy = 1;
        if (!m_issued) e_mem_req = 1;
        else if (mem_rvalid_i) begin
          if (m_if) e_if_rv = !(m_drop || flush_i);
          else      e_dm_rv = 1;
        end
      end
    end

    chk("if_gnt", if_gnt_o, e_if_gnt);
    chk("dm_gnt", dm_gnt_o, e_dm_gnt);
    chk("if_rvalid", if_rvalid_o, e_if_rv);
    chk("dm_rvalid", dm_rvalid_o, e_dm_rv);
    chk("mem_req", mem_req_o, e_mem_req);
    chk("busy", busy_o, e_busy);
    if (e_mem_req) begin
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_we", mem_we_o, m_we);
      if (m_we) begin
        chk("mem_wdata", mem_wdata_o, m_wdata);
        chk("mem_be", mem_be_o, m_be);
      end
    end
    if (e_if_rv) chk("if_rdata", if_rdata_o, mem_rdata_i);
    if (e_dm_rv && !m_we) chk("dm_rdata", dm_rdata_o, mem_rdata_i);
    if (rst_i) begin
      chk("rst_buses", {mem_addr_o, mem_wdata_o}, 64'h0);
      chk("rst_ctl", {mem_we_o, mem_be_o, if_rdata_o[0], dm_rdata_o[0]}, 64'h0);
    end

    if (rst_i) begin
      m_busy = 0; m_issued = 0; m_drop = 0; m_starve = 0;
    end else if (!m_busy) begin
      if (e_dm_gnt) begin
        m_busy = 1; m_issued = 0; m_drop = 0; m_if = 0;
        m_addr = dm_addr_i; m_we = dm_we_i; m_wdata = dm_wdata_i; m_be = dm_be_i;
        m_starve = if_req_i ? ((m_starve < LIMIT) ? m_starve + 1 : m_starve) : 0;
      end else if (e_if_gnt) begin
        m_busy = 1; m_issued = 0; m_drop = 0; m_if = 1;
        m_addr = if_addr_i; m_we = 0;
        m_starve = 0;
      end
    end else begin
      if (m_if && flush_i) m_drop = 1;
      if (!m_issued) begin
        if (mem_ready_i) m_issued = 1;
      end else if (mem_rvalid_i) begin
        m_busy = 0; m_drop = 0;
      end
    end
  end

  // ---------------- directed sequence with literal expectations ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_any_gnt(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (if_gnt_o || dm_gnt_o) return;
    end
    failures++;
    $display("FAIL %s no grant within 50 cycles", name);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (if_q.size() == 0 && dm_q.size() == 0 && !if_req_i && !dm_req_i &&
          !busy_o && !rv_pending && !acc_seen) return;
    end
    failures++;
    $display("FAIL %s traffic did not drain within 400 cycles", name);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_mem_req", mem_req_o, 1'b0);
    step(); rst_i = 1'b0;
    @(negedge clk);

    // Fetch only: gnt c0, mem_req c1, response c2, idle c3.
    if_q.push_back(32'h100);
    wait_any_gnt("t1_gnt");
    chk("t1_if_gnt_c0", if_gnt_o, 1'b1);
    @(negedge clk);
    chk("t1_mem_req_c1", mem_req_o, 1'b1);
    chk("t1_mem_addr_c1", mem_addr_o, 32'h100);
    @(negedge clk);
    chk("t1_if_rvalid_c2", if_rvalid_o, 1'b1);
    chk("t1_if_rdata_c2", if_rdata_o, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_busy_c3", busy_o, 1'b0);
    wait_drain("t1");

    // Both request: data first, then fetch, no cross-talk.
    glog = ""; if_resp.delete(); dm_resp.delete();
    dm_q.push_back('{addr: 32'h200, we: 1'b0, wdata: '0, be: 4'hF});
    if_q.push_back(32'h104);
    wait_any_gnt("t2_gnt");
    chk("t2_dm_gnt_c0", dm_gnt_o, 1'b1);
    chk("t2_if_gnt_c0", if_gnt_o, 1'b0);
    wait_drain("t2");
    chk_str("t2_order", glog, "DI");
    chk("t2_dm_resp_n", dm_resp.size(), 1);
    chk("t2_dm_resp", (dm_resp.size() > 0) ? dm_resp[0] : 32'h0, 32'hA5A5_0200);
    chk("t2_if_resp_n", if_resp.size(), 1);
    chk("t2_if_resp", (if_resp.size() > 0) ? if_resp[0] : 32'h0, 32'hA5A5_0104);

    // Store held through three not-ready cycles.
    if_resp.delete(); dm_resp.delete();
    stall_left = 3;
    dm_q.push_back('{addr: 32'h300, we: 1'b1, wdata: 32'h1234_5678, be: 4'b0011});
    wait_any_gnt("t3_gnt");
    chk("t3_dm_gnt", dm_gnt_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_mem_req", mem_req_o, 1'b1);
      chk("t3_mem_fields", {mem_addr_o, mem_wdata_o}, 64'h0000_0300_1234_5678);
      chk("t3_mem_we_be", {mem_we_o, mem_be_o}, 5'b1_0011);
    end
    @(negedge clk);
    @(negedge clk);
    chk("t3_dm_ack", dm_rvalid_o, 1'b1);
    chk("t3_no_if_rvalid", if_rvalid_o, 1'b0);
    wait_drain("t3");
    chk("t3_if_resp_n", if_resp.size(), 0);

    // Flush in WAIT, then the response arrives: dropped.
    if_resp.delete();
    rv_delay = 2;
    if_q.push_back(32'h180);
    wait_any_gnt("t4_gnt");
    step();
    step(); flush_i = 1'b1;
    step(); flush_i = 1'b0;
    @(negedge clk);
    chk("t4_dropped_rvalid", if_rvalid_o, 1'b0);
    wait_drain("t4a");
    chk("t4_no_resp", if_resp.size(), 0);

    // Flush in IDLE masks fetch for that cycle only.
    rv_delay = 0;
    if_q.push_back(32'h184);
    step(); flush_i = 1'b1;
    @(negedge clk);
    chk("t4_idle_masked", if_gnt_o, 1'b0);
    step(); flush_i = 1'b0;
    @(negedge clk);
    chk("t4_idle_regrant", if_gnt_o, 1'b1);
    wait_drain("t4b");
    chk("t4_resp_n", if_resp.size(), 1);
    chk("t4_resp", (if_resp.size() > 0) ? if_resp[0] : 32'h0, 32'hA5A5_0184);

    // Flush coinciding with the response.
    if_q.push_back(32'h188);
    wait_any_gnt("t4c_gnt");
    step();
    step(); flush_i = 1'b1;
    @(negedge clk);
    chk("t4_same_cycle_drop", if_rvalid_o, 1'b0);
    step(); flush_i = 1'b0;
    wait_drain("t4c");
    chk("t4_resp_n_after", if_resp.size(), 1);

    // Continuous contention: fairness pattern or strict data priority.
    glog = "";
    for (int i = 0; i < 10; i++)
      dm_q.push_back('{addr: 32'h400 + 32'(4 * i), we: 1'b0, wdata: '0, be: 4'hF});
    for (int i = 0; i < 3; i++) if_q.push_back(32'h500 + 32'(4 * i));
    wait_drain("t5");
    chk_str("t5_order", glog, FAIR ? "DDDDIDDDDIDDI" : "DDDDDDDDDDIII");

    // Reset in WAIT, stale response afterwards is ignored.
    if_resp.delete();
    rv_delay = 1;
    if_q.push_back(32'h600);
    wait_any_gnt("t6_gnt");
    step();
    step(); rst_i = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", busy_o, 1'b0);
    chk("t6_rst_mem_req", mem_req_o, 1'b0);
    step(); rst_i = 1'b0;
    @(negedge clk);
    chk("t6_stale_if_rvalid", if_rvalid_o, 1'b0);
    chk("t6_stale_dm_rvalid", dm_rvalid_o, 1'b0);
    chk("t6_busy_after", busy_o, 1'b0);
    rv_delay = 0;
    if_q.push_back(32'h604);
    wait_drain("t6");
    chk("t6_resp_n", if_resp.size(), 1);
    chk("t6_resp", (if_resp.size() > 0) ? if_resp[0] : 32'h0, 32'hA5A5_0604);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
